// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state type, frame constants and
// the helper that forms the transmit shift image for a freshly loaded byte.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam logic [7:0]  SPI_UNDERRUN_BYTE = 8'hFF;
    localparam int unsigned SPI_FRAME_BITS    = 8;

    // With CPH=0 the MSB goes onto MISO at load time, so the shift register
    // only keeps the remaining bits; with CPH=1 the MSB leaves on the first
    // leading edge and the whole byte is kept.
    function automatic logic [7:0] spi_tx_image(input logic [7:0] b, input logic cph);
        return cph ? b : {b[6:0], 1'b1};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized value.
// All flops reset to 1 (SPI idle-high assumption for SS).
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the asynchronous input through the chain and keep one delayed copy for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, modes 0-3, 8-bit MSB-first frames, single transmit holding
// register, RX level-valid with acknowledge.
// Optional sticky overrun flag and port: define SPI_SLAVE_OVERRUN_EN.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_m,
    input  logic       rst,
    input  logic       CPOL,
    input  logic       CPH,
    input  logic [7:0] TX_data,
    input  logic       TX_load,
    output logic       tx_ready,
    output logic [7:0] RX_data,
    output logic       RX_valid,
    input  logic       RX_ack,
    output logic       busy,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic       overrun,
`endif
    input  logic       SS,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO
);

    localparam int unsigned       CNT_W    = $clog2(SPI_FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPI_FRAME_BITS - 1);

    logic w_ss_q,   w_ss_rise,   w_ss_fall;
    logic w_sck_q,  w_sck_rise,  w_sck_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk_m), .rst_n(rst), .i_d(SS),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk_m), .rst_n(rst), .i_d(SCK),
        .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk_m), .rst_n(rst), .i_d(MOSI),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_ss_q, w_sck_q, w_mosi_rise, w_mosi_fall};

    spi_state_t        r_state;
    logic              r_cpol;
    logic              r_cph;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_tx;
    logic [7:0]        r_rx;
    logic [7:0]        r_hold;
    logic              r_hold_full;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;
    logic              r_busy;
    logic              r_miso;
    logic              r_miso_en;

    logic              w_active;
    logic              w_lead;
    logic              w_trail;
    logic              w_sample;
    logic              w_drive;
    logic              w_byte_done;
    logic              w_drive_ok;
    logic [7:0]        w_next_byte;
    logic [7:0]        w_rx_byte;

    assign w_active    = (r_state == ACTIVE);
    assign w_lead      = r_cpol ? w_sck_fall : w_sck_rise;
    assign w_trail     = r_cpol ? w_sck_rise : w_sck_fall;
    assign w_sample    = r_cph ? w_trail : w_lead;
    assign w_drive     = r_cph ? w_lead  : w_trail;
    assign w_byte_done = w_active && !w_ss_rise && w_sample && (r_cnt == CNT_LAST);
    // CPH=0: the trailing edge right after a wrap would shift past the MSB that
    // the wrap load already placed on MISO, so it is skipped (counter back at 0).
    assign w_drive_ok  = w_active && !w_ss_rise && w_drive && (r_cph || (r_cnt != '0));
    assign w_next_byte = r_hold_full ? r_hold : SPI_UNDERRUN_BYTE;
    assign w_rx_byte   = {r_rx[6:0], w_mosi_q};

    // Frame FSM, shift registers, holding register and receive outputs
    always_ff @(posedge clk_m or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cpol      <= 1'b0;
            r_cph       <= 1'b0;
            r_cnt       <= '0;
            r_tx        <= SPI_UNDERRUN_BYTE;
            r_rx        <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_miso      <= 1'b1;
            r_miso_en   <= 1'b0;
        end else begin
            if (RX_ack) begin
                r_rx_valid <= 1'b0;
            end

            if (TX_load && !r_hold_full) begin
                r_hold      <= TX_data;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        r_state   <= ACTIVE;
                        r_busy    <= 1'b1;
                        r_cpol    <= CPOL;
                        r_cph     <= CPH;
                        r_cnt     <= '0;
                        r_miso_en <= 1'b1;
                        r_miso    <= w_next_byte[7];
                        r_tx      <= spi_tx_image(w_next_byte, CPH);
                        if (r_hold_full) begin
                            r_hold_full <= 1'b0;
                        end
                    end
                end

                ACTIVE: begin
                    if (w_ss_rise) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_miso_en <= 1'b0;
                    end else begin
                        if (w_sample) begin
                            r_rx <= w_rx_byte;
                            if (r_cnt == CNT_LAST) begin
                                r_cnt <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        if (w_byte_done) begin
                            r_rx_data  <= w_rx_byte;
                            r_rx_valid <= 1'b1;
                            r_miso     <= w_next_byte[7];
                            r_tx       <= spi_tx_image(w_next_byte, r_cph);
                            if (r_hold_full) begin
                                r_hold_full <= 1'b0;
                            end
                        end else if (w_drive_ok) begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b1};
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic r_overrun;

    // Sticky flag: a byte landed on top of one the consumer had not taken
    always_ff @(posedge clk_m or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_byte_done && r_rx_valid && !RX_ack) begin
            r_overrun <= 1'b1;
        end else if (RX_ack) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;
`endif

    assign tx_ready = ~r_hold_full;
    assign RX_data  = r_rx_data;
    assign RX_valid = r_rx_valid;
    assign busy     = r_busy;
    assign MISO     = r_miso_en ? r_miso : 1'bz;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, which sets the number of synchronizer flops on SS, SCK and MOSI; legal values are 2 or 3.
REQ-002 The block SHALL have the following ports, in this order:
- clk_m  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- CPOL  in  1  SCK idle level.
- CPH  in  1  clock phase; 0 = sample on the leading edge, 1 = sample on the trailing edge.
- TX_data  in  8  next byte to return to the master.
- TX_load  in  1  write strobe for TX_data.
- tx_ready  out  1  transmit holding register empty.
- RX_data  out  8  last received byte.
- RX_valid  out  1  RX_data unread.
- RX_ack  in  1  consumer has read RX_data.
- busy  out  1  frame in progress.
- overrun  out  1  sticky lost-byte flag; present only with the macro in REQ-019.
- SS  in  1  slave select, active-low.
- SCK  in  1  serial clock from the master.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out; hi-Z while deselected.

Function
REQ-003 SS, SCK and MOSI SHALL each pass through SYNC_STAGES flops clocked by clk_m before use; SCK edges SHALL be detected from the synchronized value, giving SYNC_STAGES+1 cycles of latency.
REQ-004 Correct operation SHALL be required only for SCK high and low phases each of at least 4 clk_m cycles.
REQ-005 The FSM SHALL have two states:
- IDLE: synchronized SS is high. A synchronized SS fall moves to ACTIVE and latches CPOL and CPH.
- ACTIVE: a synchronized SS rise returns to IDLE. CPOL and CPH changes during ACTIVE SHALL be ignored.
REQ-006 Edge naming: the leading edge is the SCK transition away from the latched CPOL level; the trailing edge is the return to it.
REQ-007 Data SHALL be MSB first; 8-bit frames; bit counter 0..7, wrapping 7->0 while SS stays low (back-to-back bytes).
REQ-008 Shift register load: at entry to ACTIVE, and at each counter wrap, the shift register SHALL load the holding register if it is full, or 8'hFF (underrun byte) if it is empty. The holding register SHALL then be marked empty.
REQ-009 MISO when CPH=0: the MSB SHALL be driven in the same cycle as the shift-register load; each following bit SHALL be driven on the trailing edge.
REQ-010 MISO when CPH=1: each bit SHALL be driven on the leading edge, and MOSI SHALL be sampled on the trailing edge.
REQ-011 When CPH=0, MOSI SHALL be sampled on the leading edge.
REQ-012 After the 8th sample edge, RX_data SHALL take the received byte and RX_valid SHALL assert on the next clk_m cycle.
REQ-013 RX_valid SHALL be a level, cleared by RX_ack; if a byte completes in the same cycle as RX_ack, RX_valid SHALL stay 1 with the new data.
REQ-014 TX_load SHALL be accepted only when tx_ready=1; when tx_ready=0 it SHALL be ignored (no overwrite).
REQ-015 If TX_load coincides with a shift-register load while the holding register is empty, the shift register SHALL get 8'hFF and TX_data SHALL fill the holding register.
REQ-016 An SS rise mid-byte SHALL discard the partial byte: no RX_valid, counter reset to 0, MISO hi-Z on the next cycle; the holding register SHALL be preserved.
REQ-017 busy SHALL equal 1 exactly while the FSM is in ACTIVE.

Reset
REQ-018 While rst=0, the block SHALL force:
- FSM = IDLE and counter = 0
- shift register = 8'hFF and holding register empty (tx_ready=1)
- RX_data = 8'h00, RX_valid = 0, busy = 0
- overrun = 0 and MISO = hi-Z
- all synchronizer flops = 1

Reset asserted mid-frame SHALL abort the frame with no RX_valid.

Configuration
REQ-019 With SPI_SLAVE_OVERRUN_EN defined:
- overrun SHALL set when a byte completes while RX_valid=1 and RX_ack=0.
- RX_data SHALL still be overwritten with the new byte.
- overrun SHALL clear on RX_ack or reset.
REQ-020 Without SPI_SLAVE_OVERRUN_EN, the overrun port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-021 A shared package spi_pkg SHALL hold:
- the state encoding (IDLE, ACTIVE)
- the constant SPI_UNDERRUN_BYTE = 8'hFF
- the constant SPI_FRAME_BITS = 8
REQ-022 One sub-module spi_sync SHALL implement the SYNC_STAGES synchronizer plus rise/fall edge detect; it SHALL be instantiated three times (SS, SCK, MOSI).

Verification
REQ-023 Mode 0 (CPOL=0, CPH=0), TX_load 8'hA5, master sends 8'h3C -> MISO carries A5 MSB-first, RX_data=8'h3C, one RX_valid, tx_ready=1 after the frame starts.
REQ-024 Modes 1, 2 and 3, each with TX 8'h81 and master 8'h7E -> correct bytes in both directions for every mode.
REQ-025 Two back-to-back bytes with SS held low and only one TX_load (8'h55) -> MISO sends 55 then FF; RX_valid asserts twice.
REQ-026 SS rises after 5 SCK cycles -> no RX_valid, busy=0, MISO=Z; the next full frame is received correctly.
REQ-027 With SPI_SLAVE_OVERRUN_EN, two frames complete with no RX_ack -> overrun=1 and RX_data = the second byte; RX_ack clears both RX_valid and overrun.
REQ-028 rst pulsed low mid-frame, and TX_load issued while tx_ready=0 -> all outputs at reset values; the ignored write does not alter the held byte.
